// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic        Stop       = 1'b1;
   localparam logic        NoStop     = 1'b0;
   localparam logic        RstEnableN = 1'b0;

   typedef enum logic [1:0] {
      IfIdle    = 2'b00,
      IfReq     = 2'b01,
      IfHold    = 2'b10,
      IfDiscard = 2'b11
   } if_state_e;

   // Sequential fetch address; wraps modulo 2^32.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry pc+instruction holding register for a response that arrived while ID was stalled.
module if_hold_buf
   import if_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_inst,
   output logic        valid,
   output logic [31:0] buf_pc,
   output logic [31:0] buf_inst
);

   // Clear wins over load so a flush in the same cycle always empties the entry.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnableN) begin
         valid    <= 1'b0;
         buf_pc   <= ZeroWord;
         buf_inst <= ZeroWord;
      end else if (clear) begin
         valid    <= 1'b0;
         buf_pc   <= ZeroWord;
         buf_inst <= ZeroWord;
      end else if (load) begin
         valid    <= 1'b1;
         buf_pc   <= load_pc;
         buf_inst <= load_inst;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// MIPS32 instruction-fetch stage: owns the PC, handshakes with a wait-stated instruction memory,
// parks early responses, applies delayed-branch redirects and exception flushes.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        flush,
   input  logic [31:0] new_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        stallreq_if
);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        br_pending_q, br_pending_d;
   logic [31:0] br_target_q, br_target_d;
   // Address of a killed request; memory must see it held until its ack arrives.
   logic [31:0] disc_addr_q, disc_addr_d;

   logic        buf_load, buf_clear, buf_valid;
   logic [31:0] buf_pc, buf_inst;

   logic        valid_instr, presented, consume, br_sample;
   logic [31:0] next_pc;

   // Only stall[1] (IF/ID capture) and stall[2] (ID advance) matter to this stage.
   logic        unused_stall;
   assign unused_stall = ^{stall[5:3], stall[0]};

   assign valid_instr = ((state_q == IfReq) && imem_ack) || (state_q == IfHold);
   assign presented   = valid_instr && !flush;
   assign consume     = presented && (stall[1] == NoStop);
   assign br_sample   = branch_flag_i && (stall[2] == NoStop);
   // A branch resolving in the same edge as its delay slot is consumed redirects immediately.
   assign next_pc     = br_sample    ? branch_target_i :
                        br_pending_q ? br_target_q     : pc_plus4(pc_q);

   if_hold_buf u_hold_buf (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load),
      .clear    (buf_clear),
      .load_pc  (pc_q),
      .load_inst(imem_rdata),
      .valid    (buf_valid),
      .buf_pc   (buf_pc),
      .buf_inst (buf_inst)
   );

   // State, PC and branch bookkeeping registers.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnableN) begin
         state_q      <= IfIdle;
         pc_q         <= RESET_PC;
         br_pending_q <= 1'b0;
         br_target_q  <= ZeroWord;
         disc_addr_q  <= ZeroWord;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         br_pending_q <= br_pending_d;
         br_target_q  <= br_target_d;
         disc_addr_q  <= disc_addr_d;
      end
   end

   // Next-state, memory request and presented-instruction logic; flush overrides everything.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      br_pending_d = br_pending_q;
      br_target_d  = br_target_q;
      disc_addr_d  = disc_addr_q;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;
      imem_req     = 1'b0;
      imem_addr    = pc_q;
      if_pc        = ZeroWord;
      if_inst      = ZeroWord;

      case (state_q)
         IfIdle: begin
            state_d = IfReq;
         end
         IfReq: begin
            imem_req = !buf_valid;
            if (imem_ack) begin
               if_pc   = pc_q;
               if_inst = imem_rdata;
               if (consume) begin
                  pc_d = next_pc;
               end else begin
                  buf_load = 1'b1;
                  state_d  = IfHold;
               end
            end
         end
         IfHold: begin
            if_pc   = buf_pc;
            if_inst = buf_inst;
            if (consume) begin
               buf_clear = 1'b1;
               pc_d      = next_pc;
               state_d   = IfReq;
            end
         end
         IfDiscard: begin
            imem_req  = 1'b1;
            imem_addr = disc_addr_q;
            if (imem_ack) begin
               state_d = IfReq;
            end
         end
         default: begin
            state_d = IfIdle;
         end
      endcase

      // The consumed instruction after a taken branch is its delay slot.
      if (consume) begin
         br_pending_d = 1'b0;
      end else if (br_sample) begin
         br_pending_d = 1'b1;
         br_target_d  = branch_target_i;
      end

      if (flush) begin
         if_pc        = ZeroWord;
         if_inst      = ZeroWord;
         buf_load     = 1'b0;
         buf_clear    = 1'b1;
         br_pending_d = 1'b0;
         pc_d         = new_pc;
         case (state_q)
            IfReq: begin
               if (imem_ack) begin
                  state_d = IfReq;
               end else begin
                  state_d     = IfDiscard;
                  disc_addr_d = pc_q;
               end
            end
            IfDiscard: state_d = IfDiscard;
            default:   state_d = IfReq;
         endcase
      end
   end

   assign stallreq_if = !presented;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: sequential fetch, wait states, ID stall hold, delayed branches,
// exception flush with discard, async reset mid-hold, PC wrap and stall[2] branch gating.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        flush;
   logic [31:0] new_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        stallreq_if;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .branch_flag_i  (branch_flag_i),
      .branch_target_i(branch_target_i),
      .flush          (flush),
      .new_pc         (new_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .if_pc          (if_pc),
      .if_inst        (if_inst),
      .stallreq_if    (stallreq_if)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic ack, input logic [31:0] rd, input logic [5:0] st,
                         input logic bf, input logic [31:0] bt, input logic fl,
                         input logic [31:0] np);
      imem_ack        = ack;
      imem_rdata      = rd;
      stall           = st;
      branch_flag_i   = bf;
      branch_target_i = bt;
      flush           = fl;
      new_pc          = np;
   endtask

   // Address is only compared while a request is expected.
   task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                             input logic [31:0] pc, input logic [31:0] inst, input logic sr);
      check({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
      if (req) check({tag, ".addr"}, imem_addr, addr);
      check({tag, ".pc"}, if_pc, pc);
      check({tag, ".inst"}, if_inst, inst);
      check({tag, ".stallreq"}, {31'd0, stallreq_if}, {31'd0, sr});
   endtask

   task automatic cyc;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      set_in(1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("reset", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

      cyc(); rst = 1'b1;
      #1 expect_out("idle", 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

      // Back-to-back acks.
      cyc(); set_in(1'b1, inst_of(32'h0), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("seq0", 1'b1, 32'h0, 32'h0, inst_of(32'h0), 1'b0);
      cyc(); set_in(1'b1, inst_of(32'h4), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("seq4", 1'b1, 32'h4, 32'h4, inst_of(32'h4), 1'b0);

      // Three wait states at 0x8.
      for (int i = 0; i < 3; i++) begin
         cyc(); set_in(1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
         #1 expect_out("wait8", 1'b1, 32'h8, 32'h0, 32'h0, 1'b1);
      end
      cyc(); set_in(1'b1, inst_of(32'h8), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("ack8", 1'b1, 32'h8, 32'h8, inst_of(32'h8), 1'b0);
      cyc(); set_in(1'b1, inst_of(32'hC), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("ackC", 1'b1, 32'hC, 32'hC, inst_of(32'hC), 1'b0);

      // Ack at 0x10 while IF/ID is stalled: response parks in the hold buffer.
      cyc(); set_in(1'b1, inst_of(32'h10), 6'b000010, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("ack10st", 1'b1, 32'h10, 32'h10, inst_of(32'h10), 1'b0);
      cyc(); set_in(1'b0, 32'd0, 6'b000010, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("hold10a", 1'b0, 32'd0, 32'h10, inst_of(32'h10), 1'b0);
      cyc(); set_in(1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("hold10b", 1'b0, 32'd0, 32'h10, inst_of(32'h10), 1'b0);
      cyc(); set_in(1'b1, inst_of(32'h14), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("ack14", 1'b1, 32'h14, 32'h14, inst_of(32'h14), 1'b0);
      cyc(); set_in(1'b1, inst_of(32'h18), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("ack18", 1'b1, 32'h18, 32'h18, inst_of(32'h18), 1'b0);
      cyc(); set_in(1'b1, inst_of(32'h1C), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("ack1C", 1'b1, 32'h1C, 32'h1C, inst_of(32'h1C), 1'b0);

      // Branch resolves while its delay slot (0x20) is delivered: redirect straight to 0x40.
      cyc(); set_in(1'b1, inst_of(32'h20), 6'd0, 1'b1, 32'h40, 1'b0, 32'd0);
      #1 expect_out("dslot20", 1'b1, 32'h20, 32'h20, inst_of(32'h20), 1'b0);
      cyc(); set_in(1'b1, inst_of(32'h40), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("tgt40", 1'b1, 32'h40, 32'h40, inst_of(32'h40), 1'b0);

      // Branch resolves while delay slot 0x44 is still waiting: pending redirect to 0x80.
      cyc(); set_in(1'b0, 32'd0, 6'd0, 1'b1, 32'h80, 1'b0, 32'd0);
      #1 expect_out("wait44", 1'b1, 32'h44, 32'h0, 32'h0, 1'b1);
      cyc(); set_in(1'b1, inst_of(32'h44), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("dslot44", 1'b1, 32'h44, 32'h44, inst_of(32'h44), 1'b0);
      cyc(); set_in(1'b1, inst_of(32'h80), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("tgt80", 1'b1, 32'h80, 32'h80, inst_of(32'h80), 1'b0);

      // Flush with the 0x84 request outstanding: old address held until its ack, data dropped.
      cyc(); set_in(1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b1, 32'h180);
      #1 expect_out("flush", 1'b1, 32'h84, 32'h0, 32'h0, 1'b1);
      cyc(); set_in(1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("disc", 1'b1, 32'h84, 32'h0, 32'h0, 1'b1);
      cyc(); set_in(1'b1, 32'hBAD0_BAD0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("discack", 1'b1, 32'h84, 32'h0, 32'h0, 1'b1);
      cyc(); set_in(1'b1, inst_of(32'h180), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("hdl180", 1'b1, 32'h180, 32'h180, inst_of(32'h180), 1'b0);

      // Async reset while holding 0x184.
      cyc(); set_in(1'b1, inst_of(32'h184), 6'b000010, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("ack184st", 1'b1, 32'h184, 32'h184, inst_of(32'h184), 1'b0);
      cyc(); set_in(1'b0, 32'd0, 6'b000010, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("hold184", 1'b0, 32'd0, 32'h184, inst_of(32'h184), 1'b0);
      #2 rst = 1'b0;
      #1 expect_out("arst", 1'b0, 32'd0, 32'h0, 32'h0, 1'b1);
      cyc(); rst = 1'b1; set_in(1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("idle2", 1'b0, 32'd0, 32'h0, 32'h0, 1'b1);

      // Flush coinciding with an ack at 0x0: instruction suppressed, refetch at 0xFFFF_FFFC.
      cyc(); set_in(1'b1, inst_of(32'h0), 6'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
      #1;
      check("flushack.addr", imem_addr, 32'h0);
      check("flushack.inst", if_inst, 32'h0);
      check("flushack.pc", if_pc, 32'h0);
      cyc(); set_in(1'b1, inst_of(32'hFFFF_FFFC), 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC), 1'b0);

      // PC wraps to 0; branch presented while stall[2] is set must be ignored.
      cyc(); set_in(1'b1, inst_of(32'h0), 6'b000100, 1'b1, 32'h300, 1'b0, 32'd0);
      #1 expect_out("wrap0", 1'b1, 32'h0, 32'h0, inst_of(32'h0), 1'b0);
      cyc(); set_in(1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1 expect_out("nobr4", 1'b1, 32'h4, 32'h0, 32'h0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
